simt_scheduler: RTL and testbench

Parametrised successor to the per-core scheduler; sequences one block through IDLE/FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE/DONE.
Adds per-thread active mask and a SIMT reconvergence stack, so threads may take different branch directions instead of all following one thread's next PC.
Sits inside the compute core between fetcher/decoder, per-thread LSUs and PCs.
Core gates ALU/LSU/register/PC enables with active_mask.

---
 rtl/simt_pkg.sv | 44 ++++
 rtl/simt_group_select.sv | 81 ++++++++
 rtl/simt_scheduler.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_simt_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simt_pkg.sv
// -----------------------------------------------------------------------------
// simt_pkg
// Shared definitions for the SIMT scheduler slice:
//   core_state_t   - scheduler state encoding (IDLE..DONE, 3 bits)
//   FETCHED        - fetcher_state value meaning the instruction is available
//   LSU_REQUESTING - per-thread LSU state: request outstanding
//   LSU_WAITING    - per-thread LSU state: waiting for memory response
//   stack_entry_t  - reconvergence stack entry {pc, mask} at default widths
//   lsu_busy()     - true when an LSU state means the thread is still in memory
// -----------------------------------------------------------------------------
package simt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      REQUEST = 3'd3,
      WAIT    = 3'd4,
      EXECUTE = 3'd5,
      UPDATE  = 3'd6,
      DONE    = 3'd7
   } core_state_t;

   localparam logic [2:0] FETCHED        = 3'd2;
   localparam logic [1:0] LSU_REQUESTING = 2'd1;
   localparam logic [1:0] LSU_WAITING    = 2'd2;

   // Default block geometry; the scheduler parameters default to these.
   localparam int SIMT_THREADS     = 4;
   localparam int SIMT_PC_BITS     = 8;
   localparam int SIMT_STACK_DEPTH = 4;

   // Layout of one reconvergence entry at the default geometry. The scheduler
   // rebuilds the same {pc, mask} shape at its own parameter widths.
   typedef struct packed {
      logic [SIMT_PC_BITS-1:0] pc;
      logic [SIMT_THREADS-1:0] mask;
   } stack_entry_t;

   function automatic logic lsu_busy(input logic [1:0] st);
      return (st == LSU_REQUESTING) || (st == LSU_WAITING);
   endfunction

endpackage

// File: rtl/simt_group_select.sv
// -----------------------------------------------------------------------------
// simt_group_select (combinational)
// Splits the active threads by their next PC into at most two groups.
//   next_pc     in  packed per-thread next PC
//   active_mask in  threads currently executing
//   diverged    out 1 when the active threads do not all share one next PC
//   low_pc/low_mask   out group with the smaller PC (whole set if converged)
//   high_pc/high_mask out group with the larger PC (zero if converged)
// G0 holds every active thread matching the lowest active thread's PC; the
// remainder all follow the PC of the lowest remaining thread, so a third
// distinct target is folded into that second group rather than flagged.
// -----------------------------------------------------------------------------
module simt_group_select
   import simt_pkg::*;
#(
   parameter int THREADS = SIMT_THREADS,
   parameter int PC_BITS = SIMT_PC_BITS
) (
   input  logic [PC_BITS*THREADS-1:0] next_pc,
   input  logic [THREADS-1:0]         active_mask,
   output logic                       diverged,
   output logic [PC_BITS-1:0]         low_pc,
   output logic [THREADS-1:0]         low_mask,
   output logic [PC_BITS-1:0]         high_pc,
   output logic [THREADS-1:0]         high_mask
);

   logic [PC_BITS-1:0] pcs_s [THREADS];
   logic [PC_BITS-1:0] p0_s;
   logic [PC_BITS-1:0] p1_s;
   logic [THREADS-1:0] g0_s;
   logic [THREADS-1:0] rest_s;

   // Unpack the per-thread next PCs.
   always_comb begin
      for (int i = 0; i < THREADS; i++) begin
         pcs_s[i] = next_pc[i*PC_BITS +: PC_BITS];
      end
   end

   // Form G0 around the lowest active thread, then the remainder group.
   always_comb begin
      p0_s   = '0;
      p1_s   = '0;
      g0_s   = '0;
      rest_s = '0;
      // Descending scan: the last hit is the lowest-index thread.
      for (int i = THREADS - 1; i >= 0; i--) begin
         p0_s = active_mask[i] ? pcs_s[i] : p0_s;
      end
      for (int i = 0; i < THREADS; i++) begin
         g0_s[i] = active_mask[i] && (pcs_s[i] == p0_s);
      end
      rest_s = active_mask & ~g0_s;
      for (int i = THREADS - 1; i >= 0; i--) begin
         p1_s = rest_s[i] ? pcs_s[i] : p1_s;
      end
   end

   // Order the two groups by PC.
   always_comb begin
      diverged  = |rest_s;
      low_pc    = p0_s;
      low_mask  = g0_s;
      high_pc   = '0;
      high_mask = '0;
      if (!diverged) begin
         low_pc   = p0_s;
         low_mask = g0_s;
      end else if (p0_s < p1_s) begin
         high_pc   = p1_s;
         high_mask = rest_s;
      end else begin
         low_pc    = p1_s;
         low_mask  = rest_s;
         high_pc   = p0_s;
         high_mask = g0_s;
      end
   end

endmodule

// File: rtl/simt_scheduler.sv
// -----------------------------------------------------------------------------
// simt_scheduler
// Sequences one block through IDLE/FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE/
// DONE with a per-thread active mask and a reconvergence stack, so diverging
// threads run each branch path in turn and merge at the lower join PC.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, thread_count        kernel launch pulse and number of valid threads
//   fetcher_state              instruction fetcher state (FETCHED = 2)
//   decoded_mem_read_enable,
//   decoded_mem_write_enable   memory decodes of the current instruction
//   decoded_ret                current instruction is RET
//   lsu_state                  packed 2-bit LSU state per thread
//   next_pc                    packed next PC per thread
//   core_state                 current scheduler state
//   current_pc, active_mask    shared PC and executing threads
//   done, stack_overflow       block finished, sticky divergence overflow
// Optional build macro SIMT_SCHED_PERF_EN adds saturating perf_cycles,
// perf_instrs and perf_diverge counters.
// -----------------------------------------------------------------------------
module simt_scheduler
   import simt_pkg::*;
#(
   parameter int THREADS_PER_BLOCK = SIMT_THREADS,
   parameter int PC_BITS           = SIMT_PC_BITS,
   parameter int STACK_DEPTH       = SIMT_STACK_DEPTH
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
   input  logic [2:0]                            fetcher_state,
   input  logic                                  decoded_mem_read_enable,
   input  logic                                  decoded_mem_write_enable,
   input  logic                                  decoded_ret,
   input  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state,
   input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]  next_pc,
   output logic [2:0]                            core_state,
   output logic [PC_BITS-1:0]                    current_pc,
   output logic [THREADS_PER_BLOCK-1:0]          active_mask,
   output logic                                  done,
   output logic                                  stack_overflow
`ifdef SIMT_SCHED_PERF_EN
   ,
   output logic [31:0]                           perf_cycles,
   output logic [31:0]                           perf_instrs,
   output logic [15:0]                           perf_diverge
`endif
);

   localparam int T   = THREADS_PER_BLOCK;
   localparam int SPW = $clog2(STACK_DEPTH) + 1;
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef struct packed {
      logic [PC_BITS-1:0] pc;
      logic [T-1:0]       mask;
   } entry_t;

   core_state_t        state_r, state_next_s;
   entry_t             stack_r [STACK_DEPTH];
   logic [SPW-1:0]     sp_r, sp_next_s;
   logic [PC_BITS-1:0] pc_next_s;
   logic [T-1:0]       mask_next_s;
   logic               done_next_s, ovf_next_s;

   logic               wr_en_s;
   logic [IW-1:0]      wr_idx_s;
   entry_t             wr_entry_s;

   logic [IW-1:0]      top_idx_s, eff_idx_s;
   entry_t             top_s, eff_top_s, cand_s;
   logic [SPW-1:0]     eff_sp_s;
   logic               empty_s, full_s, overflow_s, step1_wr_s;
   logic [T-1:0]       init_mask_s;
   logic               lsu_busy_s;

   logic               diverged_s;
   logic [PC_BITS-1:0] low_pc_s, high_pc_s;
   logic [T-1:0]       low_mask_s, high_mask_s;

   // Memory decodes are part of the core interface; completion is tracked
   // through lsu_state, so they do not steer sequencing here.
   logic unused_s;
   assign unused_s = decoded_mem_read_enable ^ decoded_mem_write_enable;

   assign core_state = state_r;

   simt_group_select #(
      .THREADS (T),
      .PC_BITS (PC_BITS)
   ) u_group_select (
      .next_pc     (next_pc),
      .active_mask (active_mask),
      .diverged    (diverged_s),
      .low_pc      (low_pc_s),
      .low_mask    (low_mask_s),
      .high_pc     (high_pc_s),
      .high_mask   (high_mask_s)
   );

   // Stack top view, launch mask and LSU completion for active threads.
   always_comb begin
      top_idx_s   = IW'(sp_r - SPW'(1));
      top_s       = stack_r[top_idx_s];
      empty_s     = (sp_r == '0);
      full_s      = (sp_r == SPW'(STACK_DEPTH));
      init_mask_s = '0;
      lsu_busy_s  = 1'b0;
      for (int i = 0; i < T; i++) begin
         init_mask_s[i] = (i < int'(thread_count));
         lsu_busy_s     = lsu_busy_s | (active_mask[i] & lsu_busy(lsu_state[2*i +: 2]));
      end
   end

   // Next-state, PC/mask selection and reconvergence stack update.
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = current_pc;
      mask_next_s  = active_mask;
      done_next_s  = done;
      ovf_next_s   = stack_overflow;
      sp_next_s    = sp_r;
      wr_en_s      = 1'b0;
      wr_idx_s     = top_idx_s;
      wr_entry_s   = top_s;
      eff_top_s    = top_s;
      eff_sp_s     = sp_r;
      eff_idx_s    = top_idx_s;
      cand_s       = '{pc: low_pc_s, mask: low_mask_s};
      overflow_s   = 1'b0;
      step1_wr_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (start) begin
               pc_next_s   = '0;
               mask_next_s = init_mask_s;
               if (thread_count == '0) begin
                  state_next_s = DONE;
                  done_next_s  = 1'b1;
               end else begin
                  state_next_s = FETCH;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         FETCH: begin
            if (fetcher_state == FETCHED) begin
               state_next_s = DECODE;
            end else begin
               state_next_s = FETCH;
            end
         end
         DECODE:  state_next_s = REQUEST;
         REQUEST: state_next_s = WAIT;
         WAIT: begin
            if (lsu_busy_s) begin
               state_next_s = WAIT;
            end else begin
               state_next_s = EXECUTE;
            end
         end
         EXECUTE: state_next_s = UPDATE;
         UPDATE: begin
            if (decoded_ret) begin
               if (empty_s) begin
                  state_next_s = DONE;
                  done_next_s  = 1'b1;
               end else begin
                  pc_next_s    = top_s.pc;
                  mask_next_s  = top_s.mask;
                  sp_next_s    = sp_r - SPW'(1);
                  state_next_s = FETCH;
               end
            end else begin
               // Park the higher-PC group: join an entry already waiting at
               // that PC, otherwise push a new one.
               if (diverged_s) begin
                  if (!empty_s && (top_s.pc == high_pc_s)) begin
                     eff_top_s.mask = top_s.mask | high_mask_s;
                     step1_wr_s     = 1'b1;
                  end else if (full_s) begin
                     overflow_s = 1'b1;
                  end else begin
                     eff_top_s  = '{pc: high_pc_s, mask: high_mask_s};
                     eff_sp_s   = sp_r + SPW'(1);
                     step1_wr_s = 1'b1;
                  end
               end else begin
                  step1_wr_s = 1'b0;
               end
               eff_idx_s = IW'(eff_sp_s - SPW'(1));

               // One comparison of the candidate against the (updated) top
               // keeps the lowest pending PC running first.
               if (overflow_s) begin
                  ovf_next_s   = 1'b1;
                  done_next_s  = 1'b1;
                  state_next_s = DONE;
               end else if (eff_sp_s == '0) begin
                  pc_next_s    = cand_s.pc;
                  mask_next_s  = cand_s.mask;
                  state_next_s = FETCH;
               end else if (cand_s.pc == eff_top_s.pc) begin
                  pc_next_s    = cand_s.pc;
                  mask_next_s  = cand_s.mask | eff_top_s.mask;
                  sp_next_s    = eff_sp_s - SPW'(1);
                  state_next_s = FETCH;
               end else if (cand_s.pc > eff_top_s.pc) begin
                  wr_en_s      = 1'b1;
                  wr_idx_s     = eff_idx_s;
                  wr_entry_s   = cand_s;
                  pc_next_s    = eff_top_s.pc;
                  mask_next_s  = eff_top_s.mask;
                  sp_next_s    = eff_sp_s;
                  state_next_s = FETCH;
               end else begin
                  wr_en_s      = step1_wr_s;
                  wr_idx_s     = eff_idx_s;
                  wr_entry_s   = eff_top_s;
                  pc_next_s    = cand_s.pc;
                  mask_next_s  = cand_s.mask;
                  sp_next_s    = eff_sp_s;
                  state_next_s = FETCH;
               end
            end
         end
         DONE:    state_next_s = DONE;
         default: state_next_s = IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         current_pc     <= '0;
         active_mask    <= '0;
         done           <= 1'b0;
         stack_overflow <= 1'b0;
         sp_r           <= '0;
      end else begin
         state_r        <= state_next_s;
         current_pc     <= pc_next_s;
         active_mask    <= mask_next_s;
         done           <= done_next_s;
         stack_overflow <= ovf_next_s;
         sp_r           <= sp_next_s;
      end
   end

   // Stack storage; validity is carried entirely by sp_r.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         stack_r[wr_idx_s] <= wr_entry_s;
      end else begin
         stack_r[wr_idx_s] <= stack_r[wr_idx_s];
      end
   end

`ifdef SIMT_SCHED_PERF_EN
   logic perf_run_s;
   assign perf_run_s = (state_r != IDLE) && (state_r != DONE);

   // Saturating activity counters, live only while a block is running.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cycles  <= 32'd0;
         perf_instrs  <= 32'd0;
         perf_diverge <= 16'd0;
      end else begin
         if (perf_run_s && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
         end else begin
            perf_cycles <= perf_cycles;
         end
         if ((state_r == UPDATE) && (perf_instrs != 32'hFFFF_FFFF)) begin
            perf_instrs <= perf_instrs + 32'd1;
         end else begin
            perf_instrs <= perf_instrs;
         end
         if ((state_r == UPDATE) && !decoded_ret && diverged_s &&
             (perf_diverge != 16'hFFFF)) begin
            perf_diverge <= perf_diverge + 16'd1;
         end else begin
            perf_diverge <= perf_diverge;
         end
      end
   end
`endif

endmodule

// File: tb/tb_simt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_simt_scheduler
// Directed bench: a default-geometry scheduler plus a one-entry-stack copy
// sharing the same stimulus, used for the divergence overflow case.
// -----------------------------------------------------------------------------
module tb_simt_scheduler;
   import simt_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  thread_count;
   logic [2:0]  fetcher_state;
   logic        rd_en, wr_en, ret;
   logic [7:0]  lsu_state;
   logic [31:0] next_pc;

   logic [2:0]  core_state, core_state_o;
   logic [7:0]  current_pc, current_pc_o;
   logic [3:0]  active_mask, active_mask_o;
   logic        done, done_o, ovf, ovf_o;

   int checks = 0;
   int errors = 0;

`ifdef SIMT_SCHED_PERF_EN
   logic [31:0] pc_a, pi_a, pc_b, pi_b;
   logic [15:0] pd_a, pd_b;
`endif

   always #5 clk = ~clk;

   simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
      .fetcher_state(fetcher_state), .decoded_mem_read_enable(rd_en),
      .decoded_mem_write_enable(wr_en), .decoded_ret(ret),
      .lsu_state(lsu_state), .next_pc(next_pc),
      .core_state(core_state), .current_pc(current_pc),
      .active_mask(active_mask), .done(done), .stack_overflow(ovf)
`ifdef SIMT_SCHED_PERF_EN
      , .perf_cycles(pc_a), .perf_instrs(pi_a), .perf_diverge(pd_a)
`endif
   );

   simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .STACK_DEPTH(1)) dut_ovf (
      .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
      .fetcher_state(fetcher_state), .decoded_mem_read_enable(rd_en),
      .decoded_mem_write_enable(wr_en), .decoded_ret(ret),
      .lsu_state(lsu_state), .next_pc(next_pc),
      .core_state(core_state_o), .current_pc(current_pc_o),
      .active_mask(active_mask_o), .done(done_o), .stack_overflow(ovf_o)
`ifdef SIMT_SCHED_PERF_EN
      , .perf_cycles(pc_b), .perf_instrs(pi_b), .perf_diverge(pd_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] pk(input logic [7:0] t0, t1, t2, t3);
      return {t3, t2, t1, t0};
   endfunction

   task automatic do_reset(input string tag);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      chk({tag, ".state"}, 32'(core_state), 32'd0);
      chk({tag, ".pc"},    32'(current_pc), 32'd0);
      chk({tag, ".mask"},  32'(active_mask), 32'd0);
      chk({tag, ".done"},  32'(done), 32'd0);
      chk({tag, ".ovf"},   32'(ovf), 32'd0);
      chk({tag, ".ovf_dut_ovf"}, 32'(ovf_o), 32'd0);
   endtask

   task automatic kick(input logic [2:0] tc);
      thread_count = tc;
      start        = 1'b1;
      tick(1);
      start        = 1'b0;
   endtask

   // One instruction loop starting in FETCH; leaves the core one cycle after UPDATE.
   task automatic exec(input string tag, input logic r, input logic [31:0] npc,
                       input logic [7:0] exp_pc, input logic [3:0] exp_mask,
                       input logic [7:0] lsu, input logic exp_block);
      chk({tag, ".fetch"}, 32'(core_state), 32'd1);
      chk({tag, ".pc"},    32'(current_pc), 32'(exp_pc));
      chk({tag, ".mask"},  32'(active_mask), 32'(exp_mask));
      ret       = r;
      next_pc   = npc;
      lsu_state = lsu;
      tick(3);
      chk({tag, ".wait"}, 32'(core_state), 32'd4);
      if (exp_block) begin
         tick(1);
         chk({tag, ".stall"}, 32'(core_state), 32'd4);
         lsu_state = 8'h00;
      end
      tick(1);
      chk({tag, ".exec"}, 32'(core_state), 32'd5);
      tick(1);
      chk({tag, ".update"}, 32'(core_state), 32'd6);
      tick(1);
      lsu_state = 8'h00;
      ret       = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; thread_count = 3'd4; fetcher_state = 3'd2;
      rd_en = 1'b0; wr_en = 1'b0; ret = 1'b0; lsu_state = 8'h00; next_pc = 32'h0;
      @(negedge clk);
      do_reset("rst");

      // 1: converged program, fetch stall and LSU stall included
      kick(3'd4);
      fetcher_state = 3'd0;
      tick(2);
      chk("t1.fetch_hold", 32'(core_state), 32'd1);
      fetcher_state = 3'd2;
      exec("t1.i0", 1'b0, pk(8'd1, 8'd1, 8'd1, 8'd1), 8'd0, 4'hF, 8'h00, 1'b0);
      exec("t1.i1", 1'b0, pk(8'd2, 8'd2, 8'd2, 8'd2), 8'd1, 4'hF, 8'h01, 1'b1);
      exec("t1.i2", 1'b0, pk(8'd3, 8'd3, 8'd3, 8'd3), 8'd2, 4'hF, 8'h00, 1'b0);
      exec("t1.ret", 1'b1, pk(8'd4, 8'd4, 8'd4, 8'd4), 8'd3, 4'hF, 8'h00, 1'b0);
      chk("t1.done_state", 32'(core_state), 32'd7);
      chk("t1.done", 32'(done), 32'd1);
      kick(3'd4);
      chk("t1.start_ignored", 32'(core_state), 32'd7);
      chk("t1.done_held", 32'(done), 32'd1);

      // 2: if/else at PC 2, else path first, join at 5
      do_reset("t2.rst");
      kick(3'd4);
      exec("t2.i0", 1'b0, pk(8'd1, 8'd1, 8'd1, 8'd1), 8'd0, 4'hF, 8'h00, 1'b0);
      exec("t2.i1", 1'b0, pk(8'd2, 8'd2, 8'd2, 8'd2), 8'd1, 4'hF, 8'h00, 1'b0);
      exec("t2.br", 1'b0, pk(8'd5, 8'd5, 8'd3, 8'd3), 8'd2, 4'hF, 8'h00, 1'b0);
      exec("t2.e3", 1'b0, pk(8'hAA, 8'hAA, 8'd4, 8'd4), 8'd3, 4'b1100, 8'h00, 1'b0);
      exec("t2.e4", 1'b0, pk(8'hAA, 8'hAA, 8'd5, 8'd5), 8'd4, 4'b1100, 8'h00, 1'b0);
      exec("t2.join", 1'b1, pk(8'd6, 8'd6, 8'd6, 8'd6), 8'd5, 4'hF, 8'h00, 1'b0);
      chk("t2.done_state", 32'(core_state), 32'd7);

      // 3: loop with exit at PC 6, threads leave one group at a time
      do_reset("t3.rst");
      kick(3'd4);
      exec("t3.i0", 1'b0, pk(8'd6, 8'd6, 8'd6, 8'd6), 8'd0, 4'hF, 8'h00, 1'b0);
      exec("t3.x1", 1'b0, pk(8'd7, 8'd2, 8'd2, 8'd2), 8'd6, 4'hF, 8'h00, 1'b0);
      exec("t3.b1", 1'b0, pk(8'hAA, 8'd6, 8'd6, 8'd6), 8'd2, 4'b1110, 8'h00, 1'b0);
      exec("t3.x2", 1'b0, pk(8'hAA, 8'd7, 8'd2, 8'd2), 8'd6, 4'b1110, 8'h00, 1'b0);
      exec("t3.b2", 1'b0, pk(8'hAA, 8'hAA, 8'd6, 8'd6), 8'd2, 4'b1100, 8'h00, 1'b0);
      exec("t3.x3", 1'b0, pk(8'hAA, 8'hAA, 8'd7, 8'd7), 8'd6, 4'b1100, 8'h00, 1'b0);
      exec("t3.ret", 1'b1, pk(8'd8, 8'd8, 8'd8, 8'd8), 8'd7, 4'hF, 8'h00, 1'b0);
      chk("t3.done_state", 32'(core_state), 32'd7);

      // 3b: active group jumps past the pending join -> exchange with stack top
      do_reset("t3b.rst");
      kick(3'd4);
      exec("t3b.div", 1'b0, pk(8'd7, 8'd2, 8'd2, 8'd2), 8'd0, 4'hF, 8'h00, 1'b0);
      exec("t3b.jmp", 1'b0, pk(8'hAA, 8'd9, 8'd9, 8'd9), 8'd2, 4'b1110, 8'h00, 1'b0);
      exec("t3b.old", 1'b0, pk(8'd9, 8'hAA, 8'hAA, 8'hAA), 8'd7, 4'b0001, 8'h00, 1'b0);
      exec("t3b.ret", 1'b1, pk(8'd0, 8'd0, 8'd0, 8'd0), 8'd9, 4'hF, 8'h00, 1'b0);
      chk("t3b.done_state", 32'(core_state), 32'd7);

      // 4: nested divergence; one-entry stack overflows, four-entry stack copes
      do_reset("t4.rst");
      kick(3'd4);
      exec("t4.d1", 1'b0, pk(8'd1, 8'd1, 8'd8, 8'd8), 8'd0, 4'hF, 8'h00, 1'b0);
      exec("t4.d2", 1'b0, pk(8'd2, 8'd7, 8'hAA, 8'hAA), 8'd1, 4'b0011, 8'h00, 1'b0);
      chk("t4.ovf_flag", 32'(ovf_o), 32'd1);
      chk("t4.ovf_state", 32'(core_state_o), 32'd7);
      chk("t4.ovf_done", 32'(done_o), 32'd1);
      chk("t4.main_no_ovf", 32'(ovf), 32'd0);
      exec("t4.p2", 1'b0, pk(8'd7, 8'hAA, 8'hAA, 8'hAA), 8'd2, 4'b0001, 8'h00, 1'b0);
      exec("t4.p7", 1'b0, pk(8'd8, 8'd8, 8'hAA, 8'hAA), 8'd7, 4'b0011, 8'h00, 1'b0);
      exec("t4.ret", 1'b1, pk(8'd0, 8'd0, 8'd0, 8'd0), 8'd8, 4'hF, 8'h00, 1'b0);
      chk("t4.main_done", 32'(core_state), 32'd7);
      chk("t4.ovf_sticky", 32'(ovf_o), 32'd1);

      // 5: inactive thread LSU ignored; active thread LSU stalls; zero threads
      do_reset("t5.rst");
      kick(3'd2);
      exec("t5.i0", 1'b0, pk(8'd1, 8'd1, 8'h55, 8'h55), 8'd0, 4'b0011, 8'h80, 1'b0);
      exec("t5.i1", 1'b1, pk(8'd2, 8'd2, 8'd2, 8'd2), 8'd1, 4'b0011, 8'h04, 1'b1);
      chk("t5.done_state", 32'(core_state), 32'd7);
      do_reset("t5.rst0");
      kick(3'd0);
      chk("t5.zero_state", 32'(core_state), 32'd7);
      chk("t5.zero_done", 32'(done), 32'd1);
      chk("t5.zero_mask", 32'(active_mask), 32'd0);

      // 6: reset in WAIT with a stack entry pending, then a clean rerun
      do_reset("t6.rst");
      kick(3'd4);
      exec("t6.div", 1'b0, pk(8'd3, 8'd3, 8'd5, 8'd5), 8'd0, 4'hF, 8'h00, 1'b0);
      chk("t6.pc3", 32'(current_pc), 32'd3);
      chk("t6.mask", 32'(active_mask), 32'(4'b0011));
      next_pc = pk(8'd4, 8'd4, 8'hAA, 8'hAA);
      tick(3);
      chk("t6.in_wait", 32'(core_state), 32'd4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6.idle", 32'(core_state), 32'd0);
      chk("t6.pc0", 32'(current_pc), 32'd0);
      chk("t6.mask0", 32'(active_mask), 32'd0);
      chk("t6.done0", 32'(done), 32'd0);
      kick(3'd4);
      exec("t6.ret", 1'b1, pk(8'd1, 8'd1, 8'd1, 8'd1), 8'd0, 4'hF, 8'h00, 1'b0);
      chk("t6.empty_done", 32'(core_state), 32'd7);
      chk("t6.done", 32'(done), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
